// File: rtl/d_mem_responder.sv
// Word-addressed data memory behind a valid/ready load/store port with a
// fixed number of wait states between acceptance and response.
module d_mem_responder #(
    parameter int ADDR_WORDS  = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(ADDR_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic          lat_write;
    logic          lat_err;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_wdata;

    logic          req_err;
    logic          accept;
    logic          do_access;
    logic          acc_write;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;

    // Storage is not touched by reset; it starts out as all zeros.
    logic [31:0] mem [ADDR_WORDS] = '{default: '0};

    assign req_ready  = reset && (state == IDLE);
    assign resp_valid = (state == RESP);

    always_comb begin
        req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(ADDR_WORDS));
        accept  = req_ready && req_valid;
    end

    // With zero wait states the access happens on the accepting edge, so it
    // has to use the live request rather than the latched copy.
    always_comb begin
        if (state == IDLE) begin
            acc_write = req_write;
            acc_err   = req_err;
            acc_idx   = req_addr[AW+1:2];
            acc_wdata = req_wdata;
        end else begin
            acc_write = lat_write;
            acc_err   = lat_err;
            acc_idx   = lat_idx;
            acc_wdata = lat_wdata;
        end
        do_access = reset && ((accept && (WAIT_CYCLES == 0)) ||
                              ((state == WAIT) && (cnt == 4'd1)));
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt   = 4'(WAIT_CYCLES);
                    state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1)
                    state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            lat_write  <= 1'b0;
            lat_err    <= 1'b0;
            lat_idx    <= '0;
            lat_wdata  <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_write <= req_write;
                lat_err   <= req_err;
                lat_idx   <= req_addr[AW+1:2];
                lat_wdata <= req_wdata;
            end
            if (do_access) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_access && acc_write && !acc_err)
            mem[acc_idx] <= acc_wdata;
    end

endmodule

// File: tb/tb_d_mem_responder.sv
// Randomized self-checking bench: three responders (0, 2 and 3 wait states)
// compared against a per-instance word-array model of the load/store port.
module tb_d_mem_responder;

    localparam int N = 3;
    localparam int WC [N] = '{0, 2, 3};

    logic        clock = 1'b0;
    logic        rst        [N];
    logic        req_valid  [N];
    logic        req_write  [N];
    logic [31:0] req_addr   [N];
    logic [31:0] req_wdata  [N];
    logic        req_ready  [N];
    logic        resp_valid [N];
    logic        resp_ready [N];
    logic [31:0] resp_rdata [N];
    logic        resp_err   [N];

    logic [31:0] mdl [N][256];
    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : g_dut
        d_mem_responder #(.ADDR_WORDS(256), .WAIT_CYCLES(WC[g])) u_dut (
            .clock      (clock),
            .reset      (rst[g]),
            .req_valid  (req_valid[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_ready  (req_ready[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= 256);
    endfunction

    task automatic chk_reset_outs(input int d, input string tag);
        chk({tag, "_ready"}, 32'(req_ready[d]), 0);
        chk({tag, "_valid"}, 32'(resp_valid[d]), 0);
        chk({tag, "_rdata"}, resp_rdata[d], 0);
        chk({tag, "_err"}, 32'(resp_err[d]), 0);
    endtask

    // Called just after a negedge with instance d idle. During the RESP hold
    // an ignored store to the same address with inverted data is presented.
    task automatic txn(input int d, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input int hold);
        logic [31:0] er;
        bit ee;
        int k;
        ee = is_err(a);
        er = (ee || wr) ? 32'd0 : mdl[d][(a / 4) % 256];
        if (!ee && wr) mdl[d][(a / 4) % 256] = wd;
        chk("idle_ready", 32'(req_ready[d]), 1);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        @(posedge clock);
        #1;
        req_valid[d] = 1'b0;
        @(negedge clock);
        k = 0;
        while (!resp_valid[d] && k < 40) begin
            chk("busy_ready", 32'(req_ready[d]), 0);
            @(negedge clock);
            k++;
        end
        chk("latency", 32'(k), 32'(WC[d]));
        chk("rdata", resp_rdata[d], er);
        chk("err", 32'(resp_err[d]), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            req_valid[d] = 1'b1;
            req_write[d] = 1'b1;
            req_addr[d]  = a;
            req_wdata[d] = ~wd;
            @(negedge clock);
            chk("hold_valid", 32'(resp_valid[d]), 1);
            chk("hold_rdata", resp_rdata[d], er);
            chk("hold_err", 32'(resp_err[d]), 32'(ee));
            chk("hold_ready", 32'(req_ready[d]), 0);
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        @(negedge clock);
        resp_ready[d] = 1'b0;
        chk("done_valid", 32'(resp_valid[d]), 0);
    endtask

    task automatic rand_txn(input int d);
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        if (r < 7)       a = 32'($urandom_range(0, 31)) * 4;
        else if (r == 7) a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
        else if (r == 8) a = (32'd256 + 32'($urandom_range(0, 255))) * 4;
        else             a = $urandom;
        txn(d, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < N; d++) begin
            rst[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b0;
            for (int w = 0; w < 256; w++) mdl[d][w] = '0;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < N; d++) chk_reset_outs(d, "por");
        for (int d = 0; d < N; d++) rst[d] = 1'b1;
        @(negedge clock);

        // Store then load on the 2-wait instance, then the error cases.
        txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        txn(1, 1'b0, 32'h10, 32'h0, 0);
        txn(1, 1'b0, 32'h13, 32'h0, 0);
        txn(1, 1'b0, 32'h400, 32'h0, 0);
        txn(1, 1'b1, 32'h400, 32'h12345678, 0);
        txn(1, 1'b1, 32'h11, 32'hCAFEF00D, 0);
        txn(1, 1'b0, 32'h0, 32'h0, 0);
        txn(1, 1'b0, 32'h10, 32'h0, 5);
        txn(1, 1'b0, 32'h10, 32'h0, 0);

        // Back-to-back loads with resp_ready held high, zero wait states.
        txn(0, 1'b1, 32'h0, 32'h11111111, 0);
        txn(0, 1'b1, 32'h4, 32'h22222222, 0);
        resp_ready[0] = 1'b1;
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h0;
        chk("b2b_ready0", 32'(req_ready[0]), 1);
        @(negedge clock);
        chk("b2b_ready1", 32'(req_ready[0]), 0);
        chk("b2b_valid1", 32'(resp_valid[0]), 1);
        chk("b2b_rdata1", resp_rdata[0], mdl[0][0]);
        req_addr[0] = 32'h4;
        @(negedge clock);
        chk("b2b_ready2", 32'(req_ready[0]), 1);
        @(negedge clock);
        chk("b2b_ready3", 32'(req_ready[0]), 0);
        chk("b2b_valid3", 32'(resp_valid[0]), 1);
        chk("b2b_rdata3", resp_rdata[0], mdl[0][1]);
        req_valid[0] = 1'b0;
        @(negedge clock);
        resp_ready[0] = 1'b0;
        chk("b2b_idle", 32'(resp_valid[0]), 0);

        // Reset one cycle after accepting a store on the 3-wait instance.
        txn(2, 1'b1, 32'h10, 32'hA5A5A5A5, 0);
        txn(2, 1'b0, 32'h10, 32'h0, 0);
        req_valid[2] = 1'b1; req_write[2] = 1'b1;
        req_addr[2] = 32'h20; req_wdata[2] = 32'h5A5A5A5A;
        @(posedge clock);
        #1;
        @(negedge clock);
        rst[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk_reset_outs(2, "rst_mid");
        end
        req_valid[2] = 1'b0;
        rst[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("rst_no_resp", 32'(resp_valid[2]), 0);
        end
        txn(2, 1'b0, 32'h20, 32'h0, 0);

        for (int n = 0; n < 40; n++)
            for (int d = 0; d < N; d++) rand_txn(d);
        for (int d = 0; d < N; d++)
            for (int w = 0; w < 32; w++) txn(d, 1'b0, 32'(w * 4), 32'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/d_mem_responder.md
# d_mem_responder

Word-addressed data memory acting as the responder side of the processor's load/store port, replacing the zero-latency combinational data memory when modelling slow storage. Accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, performs the read or write, and returns a response that the initiator must acknowledge. Sits between the datapath's ALU-result/ReadData2 memory port and the storage array.

## Interface
- `ADDR_WORDS`, 256: number of 32-bit words stored. Must be a power of two, ≥ 4.
- `WAIT_CYCLES`, 2: wait states inserted between acceptance and response, range 0–15.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clock`.
- `req_valid`  in  1  initiator presents a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address; word index is `req_addr[31:2]`.
- `req_wdata`  in  32  store data.
- `req_ready`  out  1  responder can accept a request this cycle.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  initiator consumes the response.
- `resp_rdata`  out  32  load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned (`req_addr[1:0] != 0`) or out-of-range (`req_addr[31:2] >= ADDR_WORDS`) request.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready = 1`. When `req_valid & req_ready` at an edge, the request is accepted: latch write, address and wdata, and load the wait counter with `WAIT_CYCLES`. Next state is WAIT if `WAIT_CYCLES > 0`, otherwise perform the access at this same edge and go to RESP.
- WAIT: `req_ready = 0`. The counter decrements each edge. At the edge where the counter equals 1, perform the access and go to RESP.
- Access:
  - Error requests: no array write; `resp_err = 1`; `resp_rdata = 0`.
  - Stores: write the latched wdata to word `addr[31:2]`; `resp_rdata = 0`.
  - Loads: register the word into `resp_rdata`.
- RESP: `resp_valid = 1`; `resp_rdata` and `resp_err` are held stable. The FSM stays in RESP until `resp_ready` is sampled high, then returns to IDLE.
- Request inputs are ignored outside IDLE.
- Array contents are not affected by reset. The array is initialized to all-zero at simulation start.
- Counter width is 4 bits; no wrap occurs because the counter is loaded at most with 15.

## Timing
- Reset (`reset = 0` at an edge): state becomes IDLE, counter 0, `resp_valid = 0`, `resp_rdata = 0`, `resp_err = 0`. While `reset` is low, `req_ready` is forced to 0.
- Reset mid-transaction aborts it:
  - A store not yet performed is dropped.
  - A store already performed stays in the array.
  - No response is issued.
- Latency: acceptance at edge E0; `resp_valid` rises after edge E0 + `WAIT_CYCLES`. With `WAIT_CYCLES = 0`, `resp_valid` is high in the cycle right after E0.
- Response handshake: completes at the edge with `resp_valid & resp_ready`. `req_ready` is high in the following cycle.
- Throughput: at most one request per `WAIT_CYCLES + 2` cycles when `resp_ready` is held high.
- A store followed by a load to the same word returns the new data; there is no bypass requirement because requests never overlap.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10, then load 0x10 with `WAIT_CYCLES = 2` → store response `resp_err = 0`, `rdata = 0`. Load `resp_valid` rises 2 edges after acceptance with `rdata = 0xDEADBEEF`.
- `WAIT_CYCLES = 0`, back-to-back loads of 0x0 and 0x4 with `resp_ready = 1` → each response arrives 1 cycle after accept; `req_ready` pattern is 1,0,1,0.
- Load 0x13 (misaligned), then load 0x400 with `ADDR_WORDS = 256` → both give `resp_err = 1` and `rdata = 0`. The array is unchanged, checked by a later load of 0x10.
- Hold `resp_ready = 0` for 5 cycles during RESP → `resp_valid`, `rdata` and `err` stay stable, `req_ready` stays 0, and a new `req_valid` is ignored. Release → IDLE on the next cycle.
- Accept a store to 0x20 with `WAIT_CYCLES = 3`, then assert reset one cycle after accept → no response; a later load of 0x20 returns its old value (0).
- Assert `reset` low while `req_valid = 1` → `req_ready = 0`, no acceptance, all outputs 0.
